// File: rtl/tft_fill_engine.sv
// Rectangle-fill accelerator for the TFT path. Takes a window and a colour
// through a small CSR slave, then masters the LCD slave with the column/row/
// memory-write setup words followed by one colour word per pixel.
module tft_fill_engine #(
  parameter int          WR_LOW  = 2,
  parameter int          WR_HIGH = 2,
  parameter logic [15:0] CMD_COL = 16'h002A,
  parameter logic [15:0] CMD_ROW = 16'h002B,
  parameter logic [15:0] CMD_MEM = 16'h002C,
  parameter int          CW      = 18
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        avs_chipselect_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write_n,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avm_chipselect_n,
  output logic        avm_write_n,
  output logic [1:0]  avm_address,
  output logic [15:0] avm_writedata,
  output logic        eng_busy,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HOLD, S_GAP, S_FIN} state_t;

  localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW - 1);
  localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH - 1);
  localparam logic [3:0] PIX_IDX   = 4'd11;

  state_t          state;
  logic [15:0]     x0, x1, y0, y1, color;
  logic            irq_en, done, err, abort_pend;
  logic [3:0]      word_idx;
  logic [3:0]      phase_cnt;
  logic [CW-1:0]   pix_cnt;

  logic            csr_wr, ctrl_wr, start_req, clr_req, abort_req;
  logic            busy, window_bad, last_word;
  logic [CW-1:0]   dx, dy, npix;
  logic [3:0]      nxt_idx;
  logic [1:0]      nxt_addr;
  logic [15:0]     nxt_data;

  assign csr_wr     = !avs_chipselect_n && !avs_write_n;
  assign ctrl_wr    = csr_wr && (avs_address == 3'd5);
  assign start_req  = ctrl_wr && avs_writedata[0];
  assign clr_req    = ctrl_wr && avs_writedata[1];
  assign abort_req  = ctrl_wr && avs_writedata[2];
  assign busy       = (state != S_IDLE);
  assign window_bad = (x1 < x0) || (y1 < y0);

  // Pixel count is computed modulo 2^CW, which equals truncating the full product
  assign dx   = {{(CW-16){1'b0}}, x1} - {{(CW-16){1'b0}}, x0} + CW'(1);
  assign dy   = {{(CW-16){1'b0}}, y1} - {{(CW-16){1'b0}}, y0} + CW'(1);
  assign npix = dx * dy;

  // Word 10 ends the setup; with zero pixels it is the last word of the fill
  assign last_word = ((word_idx == 4'd10) && (pix_cnt == '0)) ||
                     ((word_idx == PIX_IDX) && (pix_cnt == CW'(1)));
  assign nxt_idx   = (word_idx == PIX_IDX) ? PIX_IDX : word_idx + 4'd1;

  assign eng_busy = busy;
  assign irq      = done & irq_en;

  // Payload of the word that follows the current one
  always_comb begin
    nxt_addr = 2'b11;
    nxt_data = color;
    case (nxt_idx)
      4'd1:    nxt_data = {8'h00, x0[15:8]};
      4'd2:    nxt_data = {8'h00, x0[7:0]};
      4'd3:    nxt_data = {8'h00, x1[15:8]};
      4'd4:    nxt_data = {8'h00, x1[7:0]};
      4'd5:    begin nxt_addr = 2'b10; nxt_data = CMD_ROW; end
      4'd6:    nxt_data = {8'h00, y0[15:8]};
      4'd7:    nxt_data = {8'h00, y0[7:0]};
      4'd8:    nxt_data = {8'h00, y1[15:8]};
      4'd9:    nxt_data = {8'h00, y1[7:0]};
      4'd10:   begin nxt_addr = 2'b10; nxt_data = CMD_MEM; end
      default: nxt_data = color;
    endcase
  end

  // CSR read mux, combinational from address
  always_comb begin
    avs_readdata = 16'h0000;
    case (avs_address)
      3'd0:    avs_readdata = x0;
      3'd1:    avs_readdata = x1;
      3'd2:    avs_readdata = y0;
      3'd3:    avs_readdata = y1;
      3'd4:    avs_readdata = color;
      3'd5:    avs_readdata = {12'h000, irq_en, err, done, busy};
      default: avs_readdata = 16'h0000;
    endcase
  end

  // CSR storage, control strobes and the word-sequencing FSM with registered bus outputs
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state            <= S_IDLE;
      x0               <= '0;
      x1               <= '0;
      y0               <= '0;
      y1               <= '0;
      color            <= '0;
      irq_en           <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      abort_pend       <= 1'b0;
      word_idx         <= '0;
      phase_cnt        <= '0;
      pix_cnt          <= '0;
      avm_chipselect_n <= 1'b1;
      avm_write_n      <= 1'b1;
      avm_address      <= 2'b00;
      avm_writedata    <= 16'h0000;
    end else begin
      if (csr_wr && !busy) begin
        case (avs_address)
          3'd0:    x0    <= avs_writedata;
          3'd1:    x1    <= avs_writedata;
          3'd2:    y0    <= avs_writedata;
          3'd3:    y1    <= avs_writedata;
          3'd4:    color <= avs_writedata;
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= avs_writedata[3];
      if (clr_req) done <= 1'b0;
      if (abort_req && busy && (state != S_FIN)) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start_req) begin
            done <= 1'b0;
            err  <= 1'b0;
            if (window_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              pix_cnt          <= npix;
              word_idx         <= 4'd0;
              phase_cnt        <= LOW_LOAD;
              state            <= S_LOW;
              avm_chipselect_n <= 1'b0;
              avm_write_n      <= 1'b0;
              avm_address      <= 2'b10;
              avm_writedata    <= CMD_COL;
            end
          end
        end
        S_LOW: begin
          if (phase_cnt == 4'd0) begin
            state       <= S_HOLD;
            avm_write_n <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          state            <= S_GAP;
          avm_chipselect_n <= 1'b1;
          phase_cnt        <= HIGH_LOAD;
        end
        S_GAP: begin
          if (phase_cnt != 4'd0) begin
            phase_cnt <= phase_cnt - 4'd1;
          end else if (abort_pend || abort_req) begin
            state      <= S_IDLE;
            abort_pend <= 1'b0;
          end else if (last_word) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            if (word_idx == PIX_IDX) pix_cnt <= pix_cnt - CW'(1);
            word_idx         <= nxt_idx;
            phase_cnt        <= LOW_LOAD;
            state            <= S_LOW;
            avm_chipselect_n <= 1'b0;
            avm_write_n      <= 1'b0;
            avm_address      <= nxt_addr;
            avm_writedata    <= nxt_data;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_fill_engine.sv
// Directed bench for tft_fill_engine: words seen on the LCD master port are
// captured by a monitor and compared in order against an expected-word queue.
module tb_tft_fill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic [2:0]  addr = 3'd5;
  logic        wr_n = 1'b1;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        m_cs_n, m_wr_n, busy, irq;
  logic [1:0]  m_addr;
  logic [15:0] m_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_idx = 0;
  int irq_cyc = -1;
  int hold_cnt = 0;
  int cs_low_cnt = 0;
  int busy_cnt = 0;
  logic wr_q = 1'b1;
  logic irq_q = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          obs_cyc[$];

  tft_fill_engine dut (
    .csi_clk          (clk),
    .csi_reset        (rst),
    .avs_chipselect_n (cs_n),
    .avs_address      (addr),
    .avs_write_n      (wr_n),
    .avs_writedata    (wdata),
    .avs_readdata     (rdata),
    .avm_chipselect_n (m_cs_n),
    .avm_write_n      (m_wr_n),
    .avm_address      (m_addr),
    .avm_writedata    (m_data),
    .eng_busy         (busy),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp bus events
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture each write_n falling edge and tally bus activity
  always @(negedge clk) begin
    wr_q  <= m_wr_n;
    irq_q <= irq;
    if (wr_q && !m_wr_n) begin
      obs_q.push_back({m_addr, m_data});
      obs_cyc.push_back(cyc);
    end
    if (!m_cs_n && m_wr_n) hold_cnt <= hold_cnt + 1;
    if (!m_cs_n) cs_low_cnt <= cs_low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (irq && !irq_q) irq_cyc <= cyc;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cs_n  = 1'b0;
    wr_n  = 1'b0;
    addr  = a;
    wdata = d;
    @(negedge clk);
    cs_n  = 1'b1;
    wr_n  = 1'b1;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] expected);
    logic [15:0] d;
    csr_read(a, d);
    check_output(tag, d, expected);
  endtask

  task automatic set_window(input logic [15:0] ax0, ax1, ay0, ay1, col);
    csr_write(3'd0, ax0);
    csr_write(3'd1, ax1);
    csr_write(3'd2, ay0);
    csr_write(3'd3, ay1);
    csr_write(3'd4, col);
  endtask

  task automatic push_word(input logic [1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_setup(input logic [15:0] ax0, ax1, ay0, ay1);
    push_word(2'b10, 16'h002A);
    push_word(2'b11, {8'h00, ax0[15:8]});
    push_word(2'b11, {8'h00, ax0[7:0]});
    push_word(2'b11, {8'h00, ax1[15:8]});
    push_word(2'b11, {8'h00, ax1[7:0]});
    push_word(2'b10, 16'h002B);
    push_word(2'b11, {8'h00, ay0[15:8]});
    push_word(2'b11, {8'h00, ay0[7:0]});
    push_word(2'b11, {8'h00, ay1[15:8]});
    push_word(2'b11, {8'h00, ay1[7:0]});
    push_word(2'b10, 16'h002C);
  endtask

  task automatic wait_obs(input int n, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (obs_q.size() < n) check_output(tag, obs_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_output(tag, busy, 1'b0);
  endtask

  task automatic compare_words();
    logic [17:0] e;
    while (exp_q.size() > 0) begin
      wait_obs(rd_idx + 1, "word_timeout");
      if (obs_q.size() <= rd_idx) begin
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      check_output($sformatf("word%0d", rd_idx), obs_q[rd_idx], e);
      rd_idx++;
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int base, bad, snap_cs, snap_busy;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_cs_n", m_cs_n, 1'b1);
    check_output("rst_wr_n", m_wr_n, 1'b1);
    check_output("rst_addr", m_addr, 2'b00);
    check_output("rst_data", m_data, 16'h0000);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_irq", irq, 1'b0);
    read_check("rst_status", 3'd5, 16'h0000);
    read_check("rst_x0", 3'd0, 16'h0000);
    rst = 1'b0;

    // Two-pixel red fill with irq enabled
    csr_write(3'd5, 16'h0008);
    set_window(16'd0, 16'd1, 16'd0, 16'd0, 16'hF800);
    push_setup(16'd0, 16'd1, 16'd0, 16'd0);
    push_word(2'b11, 16'hF800);
    push_word(2'b11, 16'hF800);
    base = obs_q.size();
    csr_write(3'd5, 16'h0009);
    wait_idle("a_idle");
    repeat (2) @(negedge clk);
    compare_words();
    check_output("a_count", obs_q.size() - base, 13);
    bad = 0;
    for (int i = base + 1; i < obs_q.size(); i++)
      if (obs_cyc[i] - obs_cyc[i-1] != 5) bad++;
    check_output("a_period", bad, 0);
    if (obs_q.size() > base) check_output("a_done_time", irq_cyc - obs_cyc[base], 65);
    check_output("a_irq", irq, 1'b1);
    read_check("a_status", 3'd5, 16'h000A);
    csr_write(3'd5, 16'h0002);
    check_output("a_irq_clr", irq, 1'b0);
    read_check("a_status_clr", 3'd5, 16'h0000);

    // Single pixel
    set_window(16'd5, 16'd5, 16'd7, 16'd7, 16'h1234);
    push_setup(16'd5, 16'd5, 16'd7, 16'd7);
    push_word(2'b11, 16'h1234);
    base = obs_q.size();
    csr_write(3'd5, 16'h0001);
    wait_idle("b_idle");
    repeat (2) @(negedge clk);
    compare_words();
    check_output("b_count", obs_q.size() - base, 12);
    read_check("b_status", 3'd5, 16'h0002);

    // Inverted window: error, no bus activity
    snap_cs = cs_low_cnt;
    snap_busy = busy_cnt;
    base = obs_q.size();
    csr_write(3'd0, 16'd4);
    csr_write(3'd1, 16'd3);
    csr_write(3'd5, 16'h0001);
    repeat (10) @(negedge clk);
    check_output("c_cs_low", cs_low_cnt - snap_cs, 0);
    check_output("c_busy", busy_cnt - snap_busy, 0);
    check_output("c_edges", obs_q.size() - base, 0);
    read_check("c_status", 3'd5, 16'h0006);

    // 512x512 wraps to zero pixels: setup words only
    set_window(16'd0, 16'd511, 16'd0, 16'd511, 16'hABCD);
    push_setup(16'd0, 16'd511, 16'd0, 16'd511);
    base = obs_q.size();
    csr_write(3'd5, 16'h0001);
    wait_idle("w_idle");
    repeat (2) @(negedge clk);
    compare_words();
    check_output("w_count", obs_q.size() - base, 11);
    read_check("w_status", 3'd5, 16'h0002);

    // Full screen, busy-time CSR write and restart ignored, abort during pixel 100
    set_window(16'd0, 16'd479, 16'd0, 16'd319, 16'h07E0);
    push_setup(16'd0, 16'd479, 16'd0, 16'd319);
    for (int i = 0; i < 100; i++) push_word(2'b11, 16'h07E0);
    base = obs_q.size();
    csr_write(3'd5, 16'h0001);
    wait_obs(base + 3, "f_start_timeout");
    csr_write(3'd0, 16'd9);
    csr_write(3'd5, 16'h0001);
    read_check("f_x0_locked", 3'd0, 16'h0000);
    wait_obs(base + 111, "f_pix_timeout");
    csr_write(3'd5, 16'h0004);
    repeat (20) @(negedge clk);
    compare_words();
    check_output("f_count", obs_q.size() - base, 111);
    check_output("f_busy", busy, 1'b0);
    check_output("f_cs_n", m_cs_n, 1'b1);
    read_check("f_status", 3'd5, 16'h0000);
    check_output("f_holds", hold_cnt, obs_q.size());

    // Reset during the first LOW phase
    set_window(16'd5, 16'd5, 16'd7, 16'd7, 16'h1234);
    push_word(2'b10, 16'h002A);
    base = obs_q.size();
    csr_write(3'd5, 16'h0001);
    wait_obs(base + 1, "r_start_timeout");
    rst = 1'b1;
    @(negedge clk);
    check_output("r_cs_n", m_cs_n, 1'b1);
    check_output("r_wr_n", m_wr_n, 1'b1);
    check_output("r_busy", busy, 1'b0);
    read_check("r_status", 3'd5, 16'h0000);
    read_check("r_x0", 3'd0, 16'h0000);
    read_check("r_color", 3'd4, 16'h0000);
    rst = 1'b0;
    compare_words();
    repeat (10) @(negedge clk);
    check_output("r_count", obs_q.size() - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tft_fill_engine.md
Name: tft_fill_engine

Overview:
- Hardware rectangle-fill / window-draw accelerator for the DSO TFT path; sits directly upstream of the LCD Avalon-MM slave and drives its chipselect/write/address/data inputs as an Avalon-MM-style master.
- The CPU programs a window (x0..x1, y0..y1) and a 16-bit colour through a small CSR slave and pulses start.
- The engine then emits column-set, row-set and memory-write command/parameter words followed by N identical pixel words, with programmable WR strobe timing. This offloads screen clears and waveform-area wipes from Nios.

Parameters:
- WR_LOW, 2, cycles the write strobe is held low per word (1..15)
- WR_HIGH, 2, cycles chipselect is deasserted between words (1..15)
- CMD_COL, 16'h002A, column-address-set command
- CMD_ROW, 16'h002B, row-address-set command
- CMD_MEM, 16'h002C, memory-write command
- CW, 18, pixel counter width; must cover 480*320

Ports:
- csi_clk  in  1  system clock
- csi_reset  in  1  synchronous reset, active-high
- avs_chipselect_n  in  1  CSR select, active-low
- avs_address  in  3  CSR address
- avs_write_n  in  1  CSR write strobe, active-low
- avs_writedata  in  16  CSR write data
- avs_readdata  out  16  CSR read data, combinational from address
- avm_chipselect_n  out  1  to LCD slave chipselect_n
- avm_write_n  out  1  to LCD slave write_n
- avm_address  out  2  to LCD slave address; 2'b10 = command, 2'b11 = data
- avm_writedata  out  16  to LCD slave writedata
- eng_busy  out  1  high while the engine owns the LCD bus; used by the system mux
- irq  out  1  done & irq_en

Behaviour:
- CSR map:
  - 0 X0[15:0], 1 X1, 2 Y0, 3 Y1, 4 COLOR.
  - 5 CTRL (write): bit0 start, bit1 clear done, bit2 abort, bit3 irq_en (stored).
  - 5 STATUS (read): bit0 busy, bit1 done, bit2 err, bit3 irq_en.
  - 6,7 read 0.
- CSR writes to addresses 0-4 while busy are ignored. Start while busy is ignored.
- Reset state:
  - All CSRs, done, err and irq_en are 0; FSM is IDLE.
  - Outputs: avm_chipselect_n=1, avm_write_n=1, avm_address=0, avm_writedata=0, eng_busy=0, irq=0.
  - Reset mid-operation aborts immediately to this state.
- Start (accepted in IDLE only):
  - Clears done and err.
  - If X1<X0 or Y1<Y0 (unsigned): set err, set done, no bus activity.
  - Otherwise latch npix = (X1-X0+1)*(Y1-Y0+1), truncated to CW bits, and enter the sequence on the next cycle.
- Word sequence (11 setup words, then pixels):
  - CMD_COL; then data X0[15:8], X0[7:0], X1[15:8], X1[7:0] (each zero-extended to 16 bits).
  - CMD_ROW; then Y0/Y1 bytes, same order.
  - CMD_MEM.
  - Then npix data words = COLOR.
  - Command words use avm_address=2'b10; data words use 2'b11.
- Per-word timing:
  - LOW phase, WR_LOW cycles: chipselect_n=0, write_n=0, address/data valid.
  - HOLD phase, 1 cycle: chipselect_n=0, write_n=1, address/data unchanged.
  - GAP phase, WR_HIGH cycles: chipselect_n=1, write_n=1, data held.
  - Word period is WR_LOW+1+WR_HIGH cycles (5 at defaults). address/writedata change only at the first LOW cycle.
- FSM states: IDLE, LOW, HOLD, GAP, FIN. A word index (0..10) and a pixel down-counter select the payload.
  - FIN is entered after the GAP of the last pixel; it sets done and returns to IDLE after 1 cycle.
  - eng_busy is 1 from the first LOW cycle through the FIN cycle inclusive.
- Abort:
  - Abort in LOW finishes that word's HOLD and GAP, then goes to IDLE. done is not set and busy clears.
  - Abort in GAP goes to IDLE at the end of GAP.
  - Abort in IDLE has no effect.
- Simultaneous events:
  - Start and clear-done in the same write: start wins, and done is cleared anyway.
  - Abort and start in the same write: abort wins if busy, start wins if idle.
- Wrap-around: npix is 18 bits; a product of 0 after truncation is treated as no pixel words (setup words only).

Test Plan:
- X0=0,X1=1,Y0=0,Y1=0,COLOR=16'hF800, start -> words: 2A, 00, 00, 00, 01, 2B, 00, 00, 00, 00, 2C (address 10 for 2A/2B/2C, 11 otherwise), then F800 twice. 13 write_n falling edges; done=1 exactly 65 cycles after the first LOW cycle; irq follows irq_en.
- X0=X1=5, Y0=Y1=7, single pixel -> exactly 12 words; last word is COLOR; STATUS reads 0x2 after FIN.
- X1=3,X0=4 -> err=1, done=1, avm_chipselect_n stays 1 throughout, eng_busy never rises.
- Full screen 0..479 x 0..319 -> 153611 words; CSR write X0=9 mid-fill has no effect (X0 reads back 0); a second start while busy is ignored.
- Abort during pixel 100 -> that word completes its HOLD edge, chipselect_n returns to 1, busy=0, done=0, no further write_n edges.
- csi_reset asserted during a LOW phase -> next cycle chipselect_n=1, write_n=1, all CSRs 0, STATUS=0.
